// File: rtl/ma_stage.sv
// ma_stage: memory-access pipeline stage. It issues lw/sw over a req/ack handshake,
// stalls the pipeline while an access is outstanding, and aborts after TIMEOUT wait cycles.
// Build option: define MA_ALIGN_CHECK_EN to reject word-misaligned memops without a request.
`default_nettype none

module ma_stage #(
    parameter int          TIMEOUT  = 16,
    parameter logic [31:0] ERR_DATA = 32'hFFFF_FFFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [73:0] EXResult,
    output logic [73:0] MAResult,
    output logic        delay,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        mem_err
);

    localparam logic [3:0] c_OP_LW   = 4'b1000;
    localparam logic [3:0] c_OP_SW   = 4'b1001;
    localparam logic [7:0] c_TO_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t      r_state;
    logic [73:0] r_ma;
    logic        r_req;
    logic        r_we;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic        r_err;
    logic [7:0]  r_cnt;
    logic [3:0]  r_op;
    logic [4:0]  r_dest;

    logic        w_valid;
    logic [3:0]  w_op;
    logic [4:0]  w_dest;
    logic [31:0] w_answer;
    logic        w_memop;
    logic        w_misalign;
    logic        w_issue;
    logic        w_timeout;
    logic [31:0] w_done_data;

    assign w_valid  = EXResult[73];
    assign w_op     = EXResult[72:69];
    assign w_dest   = EXResult[68:64];
    assign w_answer = EXResult[63:32];
    assign w_memop  = (w_op == c_OP_LW) || (w_op == c_OP_SW);

`ifdef MA_ALIGN_CHECK_EN
    assign w_misalign = (r_state == S_IDLE) && w_valid && w_memop && (w_answer[1:0] != 2'b00);
`else
    assign w_misalign = 1'b0;
`endif

    assign w_issue   = (r_state == S_IDLE) && w_valid && w_memop && !w_misalign;
    assign w_timeout = (r_state == S_WAIT) && (r_cnt == c_TO_LAST) && !mem_ack;

    // Ack has priority over a coincident timeout, so no error is flagged in that case.
    always_comb begin
        w_done_data = 32'h0;
        if (r_op == c_OP_LW) begin
            w_done_data = mem_ack ? mem_rdata : ERR_DATA;
        end
    end

    // Gated by reset so the stall drops the moment reset is asserted.
    assign delay = !reset &&
                   (w_issue || ((r_state == S_WAIT) && !mem_ack && !w_timeout));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_ma    <= 74'h0;
            r_req   <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= 32'h0;
            r_wdata <= 32'h0;
            r_err   <= 1'b0;
            r_cnt   <= 8'h0;
            r_op    <= 4'h0;
            r_dest  <= 5'h0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_issue) begin
                        r_op     <= w_op;
                        r_dest   <= w_dest;
                        r_req    <= 1'b1;
                        r_we     <= (w_op == c_OP_SW);
                        r_addr   <= w_answer;
                        r_wdata  <= EXResult[31:0];
                        r_cnt    <= 8'h0;
                        r_ma[73] <= 1'b0;
                        r_state  <= S_WAIT;
                    end else if (w_misalign) begin
                        r_ma  <= {1'b1, w_op, w_dest, w_answer,
                                  (w_op == c_OP_LW) ? ERR_DATA : 32'h0};
                        r_err <= 1'b1;
                    end else begin
                        r_ma <= {w_valid, w_op, w_dest, w_answer, 32'h0};
                    end
                end
                S_WAIT: begin
                    if (mem_ack || w_timeout) begin
                        r_req   <= 1'b0;
                        r_ma    <= {1'b1, r_op, r_dest, r_addr, w_done_data};
                        r_state <= S_IDLE;
                        if (!mem_ack) begin
                            r_err <= 1'b1;
                        end
                    end else if (r_cnt != 8'hFF) begin
                        r_cnt <= r_cnt + 8'h1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign MAResult  = r_ma;
    assign mem_req   = r_req;
    assign mem_we    = r_we;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign mem_err   = r_err;

endmodule

`default_nettype wire

// File: tb/tb_ma_stage.sv
// tb_ma_stage: self-checking bench for ma_stage (TIMEOUT=4) with table vectors,
// directed memory sequences and randomized transactions against a transaction-level model.
`default_nettype none

module tb_ma_stage;

    localparam int          TO  = 4;
    localparam logic [31:0] ERR = 32'hFFFF_FFFF;
    localparam logic [3:0]  LW  = 4'b1000;
    localparam logic [3:0]  SW  = 4'b1001;

    logic        clk = 1'b0;
    logic        reset;
    logic [73:0] EXResult;
    logic [73:0] MAResult;
    logic        delay;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        mem_err;

    int total = 0;
    int bad   = 0;
    logic exp_err = 1'b0;

    ma_stage #(.TIMEOUT(TO), .ERR_DATA(ERR)) dut (
        .clk(clk), .reset(reset), .EXResult(EXResult), .MAResult(MAResult),
        .delay(delay), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack), .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [73:0] act, input logic [73:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Passthrough op: result appears one edge later with zero memory answer.
    task automatic do_pass(input logic [73:0] ex, input logic [73:0] exp_ma);
        EXResult = ex;
        #1 chk("pass_delay", 74'(delay), 74'(0));
        tick();
        chk("pass_ma", MAResult, exp_ma);
        chk("pass_req", 74'(mem_req), 74'(0));
    endtask

    // Memop with ack arriving in WAIT cycle number lat (0-based); lat >= TO means no ack.
    task automatic do_mem(input logic [3:0] op, input logic [4:0] dest, input logic [31:0] addr,
                          input logic [31:0] wdata, input int lat, input logic [31:0] rdata);
        logic [31:0] exp_data;
        EXResult = {1'b1, op, dest, addr, wdata};
        mem_ack  = 1'b0;
        #1 chk("issue_delay", 74'(delay), 74'(1));
        tick();
        chk("req_up", 74'(mem_req), 74'(1));
        chk("req_we", 74'(mem_we), 74'(op == SW));
        chk("req_addr", 74'(mem_addr), 74'(addr));
        chk("req_wdata", 74'(mem_wdata), 74'(wdata));
        chk("bubble", 74'(MAResult[73]), 74'(0));
        exp_data = 32'h0;
        for (int k = 0; k < TO; k++) begin
            if (k == lat) begin
                mem_ack   = 1'b1;
                mem_rdata = rdata;
                #1 chk("ack_delay", 74'(delay), 74'(0));
                tick();
                mem_ack  = 1'b0;
                exp_data = (op == LW) ? rdata : 32'h0;
                break;
            end else if (k == TO - 1) begin
                #1 chk("to_delay", 74'(delay), 74'(0));
                tick();
                exp_data = (op == LW) ? ERR : 32'h0;
                exp_err  = 1'b1;
            end else begin
                #1 chk("wait_delay", 74'(delay), 74'(1));
                tick();
                chk("wait_req", 74'(mem_req), 74'(1));
            end
        end
        chk("mem_result", MAResult, {1'b1, op, dest, addr, exp_data});
        chk("req_down", 74'(mem_req), 74'(0));
        chk("err_flag", 74'(mem_err), 74'(exp_err));
        EXResult = 74'h0;
    endtask

    typedef struct {
        logic [73:0] ex;
        logic [73:0] ma;
    } vec_t;

    vec_t vecs[5];

    initial begin
        vecs[0] = '{ex: {1'b1, 4'b0010, 5'd3, 32'd42, 32'h1234_5678},
                    ma: {1'b1, 4'b0010, 5'd3, 32'd42, 32'h0}};
        vecs[1] = '{ex: {1'b0, 4'b0111, 5'd31, 32'hDEAD_BEEF, 32'hFFFF_FFFF},
                    ma: {1'b0, 4'b0111, 5'd31, 32'hDEAD_BEEF, 32'h0}};
        vecs[2] = '{ex: {1'b1, 4'b1010, 5'd7, 32'h0000_0103, 32'hAAAA_AAAA},
                    ma: {1'b1, 4'b1010, 5'd7, 32'h0000_0103, 32'h0}};
        vecs[3] = '{ex: {1'b1, 4'b1111, 5'd0, 32'hFFFF_FFFF, 32'h5555_5555},
                    ma: {1'b1, 4'b1111, 5'd0, 32'hFFFF_FFFF, 32'h0}};
        vecs[4] = '{ex: {1'b1, 4'b0000, 5'd16, 32'h8000_0000, 32'h1},
                    ma: {1'b1, 4'b0000, 5'd16, 32'h8000_0000, 32'h0}};

        reset     = 1'b1;
        EXResult  = 74'h0;
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
        #12;
        chk("rst_ma", MAResult, 74'h0);
        chk("rst_req", 74'(mem_req), 74'(0));
        chk("rst_we", 74'(mem_we), 74'(0));
        chk("rst_addr", 74'(mem_addr), 74'(0));
        chk("rst_wdata", 74'(mem_wdata), 74'(0));
        chk("rst_err", 74'(mem_err), 74'(0));
        reset = 1'b0;
        tick();

        for (int i = 0; i < 5; i++) do_pass(vecs[i].ex, vecs[i].ma);

        do_mem(LW, 5'd9, 32'h100, 32'h0, 3, 32'hCAFE_F00D);
        do_mem(SW, 5'd2, 32'h20, 32'h55, 0, 32'h0BAD_0BAD);
        do_mem(SW, 5'd4, 32'h40, 32'h77, 1, 32'h0);
        do_mem(LW, 5'd5, 32'h200, 32'h0, TO + 2, 32'h1111_1111);
        chk("err_sticky", 74'(mem_err), 74'(1));

        for (int n = 0; n < 60; n++) begin
            logic [3:0]  op;
            logic [4:0]  dest;
            logic [31:0] ans, dat;
            dest = 5'($urandom);
            ans  = $urandom;
            dat  = $urandom;
            if ($urandom_range(1, 0) == 1) begin
                op = ($urandom_range(1, 0) == 1) ? LW : SW;
                do_mem(op, dest, {ans[31:2], 2'b00}, dat, $urandom_range(TO + 1, 0), $urandom);
            end else begin
                logic v;
                v  = 1'($urandom);
                op = 4'($urandom_range(15, 0));
                if (op == LW || op == SW) op = 4'b0101;
                do_pass({v, op, dest, ans, dat}, {v, op, dest, ans, 32'h0});
            end
        end

`ifdef MA_ALIGN_CHECK_EN
        EXResult = {1'b1, LW, 5'd6, 32'h102, 32'h0};
        #1 chk("mis_delay", 74'(delay), 74'(0));
        tick();
        chk("mis_req", 74'(mem_req), 74'(0));
        chk("mis_ma", MAResult, {1'b1, LW, 5'd6, 32'h102, ERR});
        chk("mis_err", 74'(mem_err), 74'(1));
        EXResult = 74'h0;
`else
        do_mem(LW, 5'd6, 32'h102, 32'h0, 1, 32'h2468_ACE0);
`endif

        // Reset in the middle of an outstanding access.
        EXResult = {1'b1, LW, 5'd1, 32'h300, 32'h0};
        tick();
        chk("mid_req", 74'(mem_req), 74'(1));
        #2 reset = 1'b1;
        #1;
        chk("rw_req", 74'(mem_req), 74'(0));
        chk("rw_delay", 74'(delay), 74'(0));
        chk("rw_ma", MAResult, 74'h0);
        chk("rw_err", 74'(mem_err), 74'(0));
        EXResult = 74'h0;
        tick();
        reset = 1'b0;
        mem_ack   = 1'b1;
        mem_rdata = 32'h9999_9999;
        tick();
        mem_ack = 1'b0;
        chk("late_ack_req", 74'(mem_req), 74'(0));
        chk("late_ack_ma", MAResult, 74'h0);
        chk("late_ack_err", 74'(mem_err), 74'(0));
        chk("late_ack_delay", 74'(delay), 74'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/ma_stage.md
Name: ma_stage

Overview:
- Memory-access pipeline stage. Consumes the 74-bit EX-stage result, performs lw/sw against a data memory with a req/ack handshake, and produces the 74-bit MAResult bus consumed by the WB stage.
- Drives the pipeline-wide delay stall while a memory access is outstanding.
- Includes a bounded wait timeout with a sticky error flag.

Parameters:
- TIMEOUT, 16: maximum WAIT cycles without mem_ack before the access is aborted; legal range 2..255.
- ERR_DATA, 32'hFFFFFFFF: load data returned on a timed-out lw.

Ports:
- clk  input  1  pipeline clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- EXResult  input  74  [73] valid, [72:69] opcode, [68:64] dest, [63:32] answer (ALU result or memory address), [31:0] store data.
- MAResult  output  74  [73] valid, [72:69] opcode, [68:64] dest, [63:32] answer, [31:0] memory answer.
- delay  output  1  pipeline stall. Upstream holds EXResult stable while high; WB holds its outputs while high.
- mem_req  output  1  memory request, registered, held until ack or abort.
- mem_we  output  1  1 = store, 0 = load; valid while mem_req.
- mem_addr  output  32  word address (answer field), registered.
- mem_wdata  output  32  store data, registered.
- mem_rdata  input  32  load data, sampled on the mem_ack cycle.
- mem_ack  input  1  single-cycle completion strobe; legal only while mem_req=1.
- mem_err  output  1  sticky error flag: timeout, or misalignment when the optional feature is enabled.

Behaviour:
- Opcodes: 4'b1000 = lw, 4'b1001 = sw (memops). Opcode[3]=0 = calc. Any other opcode with [3]=1 passes through with memory answer 0.
- Reset (async): state IDLE, MAResult=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_err=0, wait counter=0. Reset during WAIT drops mem_req immediately; any late mem_ack is ignored.
- States:
  - IDLE: no access outstanding.
  - WAIT: mem_req asserted, counting.
- delay (combinational) = (IDLE & EX valid & memop) | (WAIT & !mem_ack & !timeout_hit).
- IDLE, non-memop (valid or not), on clock edge: MAResult <= {EX valid, opcode, dest, answer, 32'h0}. Latency 1 cycle.
- IDLE, memop, on clock edge:
  - Latch opcode/dest/addr/wdata internally.
  - mem_req<=1; mem_we<=(opcode==4'b1001); mem_addr<=answer; mem_wdata<=EX[31:0].
  - counter<=0; MAResult valid<=0 (bubble); state<=WAIT.
- WAIT with mem_ack, on clock edge:
  - mem_req<=0.
  - MAResult <= {1, op, dest, addr, lw ? mem_rdata : 32'h0}.
  - state<=IDLE.
  - delay is already low in this cycle, so upstream advances on the same edge. No extra bubble.
- WAIT without ack:
  - counter increments each cycle; MAResult valid stays 0.
  - timeout_hit = (counter==TIMEOUT-1) & !mem_ack.
  - On timeout_hit: same completion as ack, except memory answer = ERR_DATA for lw and mem_err<=1.
- mem_ack and timeout_hit in the same cycle: ack wins; no error.
- mem_ack outside WAIT: ignored.
- mem_err clears only on reset.
- The counter is wide enough for TIMEOUT (8 bits) and never wraps.
- Back-to-back memops: each one costs 1 issue cycle plus the ack latency. No overlap; at most one outstanding access.

Optional Feature:
- Macro: MA_ALIGN_CHECK_EN.
- Defined: a memop in IDLE with answer[1:0]!=0 issues no memory request. On the next edge:
  - MAResult <= {1, op, dest, answer, lw ? ERR_DATA : 0}.
  - mem_err<=1.
  - delay stays low for that op.
- Undefined: no check; the address is forwarded unmodified.

Test Plan:
- Calc op: EX={1,4'b0010,5'd3,32'd42,x} in IDLE -> next cycle MAResult={1,4'b0010,3,42,0}, delay=0, mem_req=0.
- lw, ack after 3 WAIT cycles with rdata=32'hCAFEF00D, addr=32'h100:
  - delay=1 in the issue cycle and the WAIT cycles before ack; mem_req=1 and mem_addr=32'h100 from the cycle after issue.
  - MAResult={1,4'b1000,dest,32'h100,32'hCAFEF00D} after the ack edge.
  - mem_req=0 after the ack edge.
- sw with addr=32'h20, data=32'h55, ack in the first WAIT cycle -> mem_we=1, mem_wdata=32'h55; MAResult data field 0; total delay of 1 cycle.
- Timeout, TIMEOUT=4, lw, no ack -> mem_req drops after 4 WAIT cycles; MAResult data=32'hFFFFFFFF; mem_err=1 and stays 1.
- Reset asserted mid-WAIT -> mem_req, delay, MAResult and mem_err go to 0 immediately; a subsequent mem_ack has no effect.
- With MA_ALIGN_CHECK_EN, lw to addr=32'h102 -> no mem_req; MAResult data=32'hFFFFFFFF; mem_err=1.
